// File: rtl/mips_mem_pkg.sv
// Shared store-path definitions for the MEM stage.
// Contents: store type encodings, the full-word byte-enable constant and the
// store buffer entry struct used by mem_store_buffer and store_align.
package mips_mem_pkg;

    localparam logic [1:0] ST_SW  = 2'b00;
    localparam logic [1:0] ST_SH  = 2'b01;
    localparam logic [1:0] ST_SB  = 2'b10;
    localparam logic [1:0] ST_RSV = 2'b11;

    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef struct packed {
        logic [31:0] addr;   // word-aligned, [1:0] always 00
        logic [31:0] wdata;  // lane-replicated store data
        logic [3:0]  be;     // bit i enables byte lane i
    } store_entry_t;

endpackage

// File: rtl/store_align.sv
// Store alignment: maps a store type, the low address bits and the register
// value onto byte enables and lane-replicated write data.
// Ports:
//   stType  - 00 sw, 01 sh, 10 sb, 11 reserved
//   addrLo  - st_addr[1:0]
//   stData  - register rt value
//   legal   - store is aligned and of a defined type
//   be      - byte enables, bit i = byte lane i
//   wdata   - replicated write data
// Purely combinational; shared with the cache write path.
module store_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  stType,
    input  logic [1:0]  addrLo,
    input  logic [31:0] stData,
    output logic        legal,
    output logic [3:0]  be,
    output logic [31:0] wdata
);

    always_comb begin
        legal = 1'b0;
        be    = 4'b0000;
        wdata = 32'h0;
        case (stType)
            ST_SW: begin
                legal = (addrLo == 2'b00);
                be    = BE_WORD;
                wdata = stData;
            end
            ST_SH: begin
                legal = !addrLo[0];
                be    = addrLo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{stData[15:0]}};
            end
            ST_SB: begin
                legal = 1'b1;
                be    = 4'b0001 << addrLo;
                wdata = {4{stData[7:0]}};
            end
            default: ; // reserved type: illegal, no enables
        endcase
    end

endmodule

// File: rtl/mem_store_buffer.sv
// MEM-stage store buffer.
// Accepts sw/sh/sb stores, aligns them into word address + byte enables +
// replicated data, queues them in a DEPTH-entry FIFO and drains the head to
// data memory over a req/ack handshake. Flags loads that hit a pending store.
// Ports:
//   clk, reset            - clock, synchronous active-low reset
//   st_valid/st_ready     - store request handshake (st_ready = not full)
//   st_addr/st_data/st_type - store byte address, rt value, type
//   st_err                - one-cycle pulse after an illegal store is rejected
//   ld_check/ld_addr      - load issued this cycle and its byte address
//   ld_hazard             - load word matches a pending store
//   mem_req/mem_ack       - write request to memory and its acceptance
//   mem_addr/mem_wdata/mem_be - head entry (all zero while empty)
//   empty                 - no pending entries
module mem_store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_type,
    output logic        st_err,
    input  logic        ld_check,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]   rdPtr, wrPtr, count;
    logic [PTR_W-1:0] rdIdx, wrIdx;
    store_entry_t     entries [DEPTH];
    logic [DEPTH-1:0] entryValid;
    store_entry_t     head;

    logic        legal;
    logic [3:0]  alignBe;
    logic [31:0] alignWdata;
    logic        push, pop;
    logic        hazardHit;
    logic        unusedLdLo;

    store_align uAlign (
        .stType (st_type),
        .addrLo (st_addr[1:0]),
        .stData (st_data),
        .legal  (legal),
        .be     (alignBe),
        .wdata  (alignWdata)
    );

    assign rdIdx = rdPtr[PTR_W-1:0];
    assign wrIdx = wrPtr[PTR_W-1:0];
    assign head  = entries[rdIdx];

    assign empty    = (rdPtr == wrPtr);
    // Registered count only, so a same-cycle pop never opens a slot early.
    assign st_ready = (count != CNT_FULL);
    assign mem_req  = !empty;

    assign push = st_valid && st_ready && legal;
    assign pop  = mem_req && mem_ack;

    assign mem_addr  = empty ? 32'h0 : head.addr;
    assign mem_wdata = empty ? 32'h0 : head.wdata;
    assign mem_be    = empty ? 4'b0  : head.be;

    // Word granularity: any overlap in the same word is a hazard, and an
    // entry being popped this cycle is still valid until the edge.
    always_comb begin
        hazardHit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i] && (entries[i].addr[31:2] == ld_addr[31:2]))
                hazardHit = 1'b1;
        end
    end
    assign ld_hazard  = ld_check && hazardHit;
    assign unusedLdLo = ^ld_addr[1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            entryValid <= '0;
            st_err     <= 1'b0;
        end else begin
            st_err <= st_valid && !legal;
            if (pop) begin
                rdPtr             <= rdPtr + 1'b1;
                entryValid[rdIdx] <= 1'b0;
            end
            if (push) begin
                wrPtr             <= wrPtr + 1'b1;
                entryValid[wrIdx] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset: valid bits and pointers gate every use.
    always_ff @(posedge clk) begin
        if (push)
            entries[wrIdx] <= '{addr: {st_addr[31:2], 2'b00}, wdata: alignWdata, be: alignBe};
    end

endmodule

// File: doc/mem_store_buffer.md
Name: mem_store_buffer

Overview:
Store-side counterpart of the writeback load/ALU select path. It accepts store requests from the MEM stage and converts sw/sh/sb into word-aligned data, byte enables and replicated write data. Entries are buffered in a small FIFO and drained to data memory over a req/ack handshake. It also flags load-after-store hazards so the pipeline can stall loads that hit a pending store.

Parameters:
DEPTH, 2, FIFO entries; power of 2, range 2..8
PTR_W, 1, log2(DEPTH); derived, not overridden

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
st_valid  in  1  MEM stage presents a store
st_ready  out  1  buffer can accept; equals !full
st_addr  in  32  byte address of store
st_data  in  32  register rt value
st_type  in  2  00 sw, 01 sh, 10 sb, 11 reserved
st_err  out  1  one-cycle pulse: misaligned or reserved store rejected
ld_check  in  1  MEM stage is issuing a load this cycle
ld_addr  in  32  byte address of that load
ld_hazard  out  1  load word matches a pending store
mem_req  out  1  write request to data memory
mem_ack  in  1  memory accepted current write
mem_addr  out  32  word-aligned address, bits [1:0] = 00
mem_wdata  out  32  replicated write data
mem_be  out  4  byte enables, bit i = byte lane i
empty  out  1  no pending entries

Behaviour:
- Reset (reset==0 at clk edge): rd/wr pointers and count = 0, all entry valid bits cleared, mem_req=0, st_err=0, empty=1. mem_addr/mem_wdata/mem_be read 0 while empty.
- Reset mid-transaction: pending entries are discarded and mem_req drops the same edge. Memory must ignore an un-acked request.
- Enqueue condition: st_valid && st_ready && legal.
- Legality:
  - sw needs addr[1:0]==00.
  - sh needs addr[0]==0.
  - sb is always legal.
  - type 11 is illegal.
- Illegal store: not enqueued; st_err=1 for exactly the next cycle.
- Entry encoding:
  - sw: be=1111, wdata=st_data.
  - sh: be = addr[1] ? 1100 : 0011; wdata={2{st_data[15:0]}}.
  - sb: be = 0001 << addr[1:0]; wdata={4{st_data[7:0]}}.
  - Every entry stores addr = {st_addr[31:2],2'b00}.
- Latency: an entry enqueued at edge N drives mem_req=1 from cycle N+1 (registered FIFO, no bypass).
- Handshake:
  - mem_req = !empty. mem_addr/wdata/be come from the head entry and stay stable while mem_req && !mem_ack.
  - mem_ack is sampled only when mem_req=1; ack with mem_req=0 is ignored.
  - On mem_req && mem_ack, the head is popped at that edge. If another entry is present, mem_req stays 1 and the outputs update to it the next cycle, so back-to-back ack yields one store per cycle.
- Full: count==DEPTH drives st_ready=0. An enqueue attempted while full is not taken, even if a pop happens the same cycle; st_ready is a function of registered count only.
- Simultaneous enqueue and pop when not full: count unchanged, both pointers advance.
- Wrap-around: pointers are PTR_W+1 bits. full = MSBs differ and low bits equal; empty = pointers equal.
- ld_hazard (combinational) = ld_check && any valid entry with entry.addr[31:2]==ld_addr[31:2]. Any byte overlap within the word counts. An entry popped this cycle still counts this cycle.
- Arithmetic: count is PTR_W+1 bits and never exceeds DEPTH. No other arithmetic.

Decomposition:
- Shared package mips_mem_pkg: ST_SW/ST_SH/ST_SB/ST_RSV encodings, BE_WORD=4'b1111, store_entry struct {addr[31:0], wdata[31:0], be[3:0]}.
- One natural sub-module: store_align (combinational) maps st_type/st_addr/st_data to {legal, be, wdata}; reused later by the cache write path.
- FIFO and handshake stay in mem_store_buffer.

Test Plan:
- sb addr=0x0000_1003 data=0x1234_56AB, ack held 1 -> mem_req 1 cycle after accept, mem_addr=0x0000_1000, be=1000, wdata=0xABABABAB, empty=1 after pop.
- sh addr=0x0000_2002 data=0x0000_BEEF; sw addr=0x0000_2001 -> sh yields be=1100, wdata=0xBEEFBEEF; the sw is rejected with a 1-cycle st_err pulse and no entry; type 11 is rejected the same way.
- mem_ack=0, three sw to 0x10/0x14/0x18 -> first two accepted, st_ready=0 on the third until an ack. Outputs stay frozen at 0x10 while stalled. Then ack for 3 cycles -> 0x10, 0x14, 0x18 in order, back-to-back, after which mem_req falls.
- Pending sb to 0x0000_3001; ld_check with ld_addr=0x0000_3002 -> ld_hazard=1; ld_addr=0x0000_3004 -> 0; after pop, 0x3002 -> 0.
- Continuous 1-per-cycle sw with alternating ack over 20 stores -> all 20 writes in order with correct addresses, no loss or duplication across pointer wrap.
- reset low while mem_req=1 with 2 entries -> next cycle mem_req=0, empty=1, st_err=0; a store after reset release is accepted normally.
